// File: rtl/mcs4.sv
// Shared MCS-4 bus types: 4-bit data character and the eight-phase
// instruction cycle.
package mcs4;

  typedef logic [3:0] char_t;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } instr_cyc_t;

endpackage

// File: rtl/mcs4_ram_bank_if.sv
// Host-side random-access port of the RAM bank. The host (master) holds
// host_req until it sees the one-cycle host_ack from the bank (slave).
interface mcs4_ram_bank_if;

  logic       host_req;
  logic       host_we;
  logic [8:0] host_addr;   // {chip[8:7], reg[6:5], is_status[4], char[3:0]}
  logic [3:0] host_wdata;
  logic [3:0] host_rdata;
  logic       host_ack;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );

endinterface

// File: rtl/mcs4_ram_bank.sv
// Multi-chip 4002-class RAM bank on one CM-RAM line. Tracks the 8-phase
// instruction cycle, latches SRC address and I/O command, serves CPU
// reads/writes at X1/X2 and gives the host port every other slot.
//
// Instruction-cycle phases (icyc_q):
//   state | meaning
//   A1-A3 | address nibbles on the bus, host may access
//   M1    | OPR nibble, host may access
//   M2    | OPA nibble: command latched when cm_ram is high
//   X1    | CPU slot: read data fetched into the output register
//   X2    | CPU slot: bus driven for reads, writes committed, SRC chip/reg
//   X3    | SRC char latched, host may access
module mcs4_ram_bank #(
  parameter int NUM_CHIPS     = 4,
  parameter int REGS_PER_CHIP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync,
  input  logic                   cm_ram,
  input  mcs4::char_t            dbus_in,
  output mcs4::char_t            dbus_out,
  output logic                   dbus_oe,
  output logic [4*NUM_CHIPS-1:0] io_out,
  mcs4_ram_bank_if.slave         host
);
  import mcs4::*;

  localparam logic [2:0] NC = 3'(NUM_CHIPS);
  localparam logic [2:0] NR = 3'(REGS_PER_CHIP);

  localparam char_t OPA_WRM = 4'h0;
  localparam char_t OPA_WMP = 4'h1;
  localparam char_t OPA_SBM = 4'h8;
  localparam char_t OPA_RDM = 4'h9;
  localparam char_t OPA_ADM = 4'hB;

  instr_cyc_t             icyc_q, icyc_d;
  char_t                  opa_q, opa_d;
  logic                   opa_rcv_q, opa_rcv_d;
  logic                   src_rcv_q, src_rcv_d;
  logic [1:0]             chip_q, chip_d;
  logic [1:0]             rsel_q, rsel_d;
  char_t                  cix_q, cix_d;
  char_t                  dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic [4*NUM_CHIPS-1:0] io_q, io_d;
  logic                   ack_q, ack_d;
  char_t                  rdata_q, rdata_d;

  // Full 4x4 arrays keep index widths fixed; only the selected range is used.
  char_t main_mem [4][4][16];
  char_t stat_mem [4][4][4];

  logic       cpu_sel, cpu_rd, cpu_rd_stat, cpu_wr;
  char_t      cpu_rdata;
  logic [1:0] h_chip, h_reg;
  logic       h_stat, h_sel, host_go;
  char_t      h_cix, host_mem;
  logic       we_main, we_stat;
  logic [1:0] wa_chip, wa_reg;
  char_t      wa_cix, wa_data;

  assign h_chip = host.host_addr[8:7];
  assign h_reg  = host.host_addr[6:5];
  assign h_stat = host.host_addr[4];
  assign h_cix  = host.host_addr[3:0];

  // Address decode, read muxes and the single shared memory write port.
  always_comb begin
    cpu_sel     = ({1'b0, chip_q} < NC) && ({1'b0, rsel_q} < NR);
    cpu_rd_stat = (opa_q[3:2] == 2'b11);
    cpu_rd      = cpu_rd_stat || (opa_q == OPA_SBM) || (opa_q == OPA_RDM) ||
                  (opa_q == OPA_ADM);
    cpu_rdata   = cpu_rd_stat ? stat_mem[chip_q][rsel_q][opa_q[1:0]]
                              : main_mem[chip_q][rsel_q][cix_q];
    cpu_wr      = (icyc_q == X2) && opa_rcv_q && cpu_sel;

    h_sel    = ({1'b0, h_chip} < NC) && ({1'b0, h_reg} < NR);
    host_go  = host.host_req && !ack_q && (icyc_q != X1) && (icyc_q != X2);
    host_mem = h_stat ? stat_mem[h_chip][h_reg][h_cix[1:0]]
                      : main_mem[h_chip][h_reg][h_cix];

    // CPU writes only land at X2 and the host never runs there, so the
    // two sources can share one port without arbitration.
    we_main = 1'b0;
    we_stat = 1'b0;
    wa_chip = chip_q;
    wa_reg  = rsel_q;
    wa_cix  = cix_q;
    wa_data = dbus_in;
    if (!rst) begin
      if (cpu_wr) begin
        we_main = (opa_q == OPA_WRM);
        we_stat = (opa_q[3:2] == 2'b01);
        if (opa_q[3:2] == 2'b01) wa_cix = {2'b00, opa_q[1:0]};
      end else if (host_go && host.host_we && h_sel) begin
        we_main = !h_stat;
        we_stat = h_stat;
        wa_chip = h_chip;
        wa_reg  = h_reg;
        wa_cix  = h_stat ? {2'b00, h_cix[1:0]} : h_cix;
        wa_data = host.host_wdata;
      end
    end
  end

  // Next-state: phase counter, command/SRC latches, bus drive, ports, host.
  always_comb begin
    icyc_d    = sync ? A1 : instr_cyc_t'(icyc_q + 3'd1);
    opa_d     = opa_q;
    opa_rcv_d = opa_rcv_q;
    src_rcv_d = src_rcv_q;
    chip_d    = chip_q;
    rsel_d    = rsel_q;
    cix_d     = cix_q;
    dout_d    = 4'h0;
    oe_d      = 1'b0;
    io_d      = io_q;
    ack_d     = host_go;
    rdata_d   = (host_go && h_sel) ? host_mem : 4'h0;

    case (icyc_q)
      M2: begin
        opa_rcv_d = cm_ram;
        opa_d     = dbus_in;
      end
      X1: begin
        if (opa_rcv_q && cpu_rd && cpu_sel) begin
          dout_d = cpu_rdata;
          oe_d   = 1'b1;
        end
      end
      X2: begin
        src_rcv_d = cm_ram;
        if (cm_ram) {chip_d, rsel_d} = dbus_in;
        for (int n = 0; n < NUM_CHIPS; n++) begin
          if (cpu_wr && (opa_q == OPA_WMP) && (chip_q == 2'(n)))
            io_d[4*n +: 4] = dbus_in;
        end
      end
      X3: begin
        if (src_rcv_q) cix_d = dbus_in;
      end
      default: ;
    endcase
  end

  // Control registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      icyc_q    <= A1;
      opa_q     <= 4'h0;
      opa_rcv_q <= 1'b0;
      src_rcv_q <= 1'b0;
      chip_q    <= 2'b00;
      rsel_q    <= 2'b00;
      cix_q     <= 4'h0;
      dout_q    <= 4'h0;
      oe_q      <= 1'b0;
      io_q      <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= 4'h0;
    end else begin
      icyc_q    <= icyc_d;
      opa_q     <= opa_d;
      opa_rcv_q <= opa_rcv_d;
      src_rcv_q <= src_rcv_d;
      chip_q    <= chip_d;
      rsel_q    <= rsel_d;
      cix_q     <= cix_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      io_q      <= io_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  // RAM and status storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_main) main_mem[wa_chip][wa_reg][wa_cix] <= wa_data;
    if (we_stat) stat_mem[wa_chip][wa_reg][wa_cix[1:0]] <= wa_data;
  end

  assign dbus_out        = dout_q;
  assign dbus_oe         = oe_q;
  assign io_out          = io_q;
  assign host.host_ack   = ack_q;
  assign host.host_rdata = rdata_q;

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Bench for mcs4_ram_bank: directed scenarios plus randomized CPU/host
// traffic against an array-based model of the bank's contents.
module tb_mcs4_ram_bank;

  localparam int NC = 3;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst, sync, cm_ram;
  logic [3:0]    dbus_in, dbus_out;
  logic          dbus_oe;
  logic [4*NC-1:0] io_out;

  mcs4_ram_bank_if hif ();

  mcs4_ram_bank #(.NUM_CHIPS(NC), .REGS_PER_CHIP(NR)) dut (
    .clk(clk), .rst(rst), .sync(sync), .cm_ram(cm_ram),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .io_out(io_out), .host(hif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  bit pending = 0;
  int h_lat = 0;
  logic [3:0] h_rd = 4'h0;
  int spurious = 0;
  int raise_ph = -1;
  int oe_cnt;
  bit oe_bad;
  logic [3:0] rd_val;

  // model of the bank
  int m_chip, m_reg, m_char;
  logic [3:0] m_main [4][4][16];
  logic [3:0] m_stat [4][4][4];
  logic [3:0] m_io [4];

  function automatic bit m_sel();
    return (m_chip < NC) && (m_reg < NR);
  endfunction

  function automatic bit is_read(input logic [3:0] opa);
    return (opa == 4'h8) || (opa == 4'h9) || (opa == 4'hB) || (opa >= 4'hC);
  endfunction

  function automatic logic [3:0] m_read(input logic [3:0] opa);
    if (opa >= 4'hC) return m_stat[m_chip][m_reg][int'(opa) - 12];
    return m_main[m_chip][m_reg][m_char];
  endfunction

  task automatic m_write(input logic [3:0] opa, input logic [3:0] d);
    if (!m_sel()) return;
    if (opa == 4'h0) m_main[m_chip][m_reg][m_char] = d;
    else if (opa == 4'h1) m_io[m_chip] = d;
    else if (opa >= 4'h4 && opa <= 4'h7) m_stat[m_chip][m_reg][int'(opa) - 4] = d;
  endtask

  function automatic logic [4*NC-1:0] m_io_vec();
    logic [4*NC-1:0] v = '0;
    for (int n = 0; n < NC; n++) v[4*n +: 4] = m_io[n];
    return v;
  endfunction

  function automatic logic [8:0] haddr(input int c, input int r, input int st, input int ch);
    return {2'(c), 2'(r), 1'(st), 4'(ch)};
  endfunction

  function automatic logic [3:0] h_exp(input logic [8:0] a);
    int c = int'(a[8:7]);
    int r = int'(a[6:5]);
    if (c >= NC || r >= NR) return 4'h0;
    if (a[4]) return m_stat[c][r][int'(a[1:0])];
    return m_main[c][r][int'(a[3:0])];
  endfunction

  task automatic m_host(input bit we, input logic [8:0] a, input logic [3:0] wd);
    int c = int'(a[8:7]);
    int r = int'(a[6:5]);
    if (!we || c >= NC || r >= NR) return;
    if (a[4]) m_stat[c][r][int'(a[1:0])] = wd;
    else m_main[c][r][int'(a[3:0])] = wd;
  endtask

  // one clock; tracks the bench's own phase and captures host acks
  task automatic tick();
    bit s;
    s = sync;
    if (pending) h_lat++;
    @(posedge clk);
    #1;
    ph = s ? 0 : (ph + 1) % 8;
    if (hif.host_ack === 1'b1) begin
      if (pending) begin
        h_rd = hif.host_rdata;
        pending = 0;
        hif.host_req = 1'b0;
      end else spurious++;
    end
  endtask

  task automatic host_wait();
    int g = 0;
    while (pending && g < 12) begin
      tick();
      g++;
    end
    checks++;
    if (pending) begin
      $display("FAIL host_ack_timeout: got no ack, expected ack within 12 clocks");
      errors++;
      hif.host_req = 1'b0;
      pending = 0;
    end
  endtask

  task automatic host_op(input bit we, input logic [8:0] a, input logic [3:0] wd);
    hif.host_we = we;
    hif.host_addr = a;
    hif.host_wdata = wd;
    hif.host_req = 1'b1;
    pending = 1;
    h_lat = 0;
    host_wait();
    m_host(we, a, wd);
  endtask

  // one full instruction cycle A1..X3, sync during X3
  task automatic run_instr(input bit m2cm, input logic [3:0] opa, input bit x2cm,
                           input logic [3:0] x2d, input logic [3:0] x3d);
    int g = 0;
    sync = 1'b0;
    cm_ram = 1'b0;
    dbus_in = 4'h0;
    while (ph != 0 && g < 16) begin
      tick();
      g++;
    end
    oe_cnt = 0;
    oe_bad = 0;
    rd_val = 4'h0;
    for (int p = 0; p < 8; p++) begin
      if (dbus_oe === 1'b1) begin
        oe_cnt++;
        if (p == 6) rd_val = dbus_out;
        else oe_bad = 1;
      end else if (dbus_out !== 4'h0) oe_bad = 1;
      cm_ram = (p == 4) ? m2cm : (p == 6) ? x2cm : 1'b0;
      dbus_in = (p == 4) ? opa : (p == 6) ? x2d : (p == 7) ? x3d : 4'h0;
      sync = (p == 7);
      if (p == raise_ph && !pending) begin
        hif.host_req = 1'b1;
        pending = 1;
        h_lat = 0;
      end
      tick();
    end
    sync = 1'b0;
    cm_ram = 1'b0;
    dbus_in = 4'h0;
    raise_ph = -1;
  endtask

  task automatic cpu_src(input int c, input int r, input int ch);
    run_instr(1'b0, 4'h0, 1'b1, {2'(c), 2'(r)}, 4'(ch));
    m_chip = c;
    m_reg = r;
    m_char = ch;
  endtask

  task automatic cpu_cmd(input logic [3:0] opa, input logic [3:0] d);
    run_instr(1'b1, opa, 1'b0, d, 4'h0);
    m_write(opa, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; sync = 1'b0; cm_ram = 1'b0; dbus_in = 4'h0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = 4'h0;
    repeat (3) tick();
    checks++; if (dbus_out !== 4'h0) begin $display("FAIL reset_dbus_out: got %h expected 0", dbus_out); errors++; end
    checks++; if (dbus_oe !== 1'b0) begin $display("FAIL reset_dbus_oe: got %b expected 0", dbus_oe); errors++; end
    checks++; if (io_out !== '0) begin $display("FAIL reset_io_out: got %h expected 0", io_out); errors++; end
    checks++; if (hif.host_ack !== 1'b0) begin $display("FAIL reset_host_ack: got %b expected 0", hif.host_ack); errors++; end
    checks++; if (hif.host_rdata !== 4'h0) begin $display("FAIL reset_host_rdata: got %h expected 0", hif.host_rdata); errors++; end
    rst = 1'b0;
    ph = 0;
    m_chip = 0; m_reg = 0; m_char = 0;
    for (int n = 0; n < 4; n++) m_io[n] = 4'h0;
    spurious = 0;
  endtask

  task automatic preload();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) begin
        for (int ch = 0; ch < 16; ch++) host_op(1'b1, haddr(c, r, 0, ch), 4'($urandom_range(0, 15)));
        for (int s = 0; s < 4; s++) host_op(1'b1, haddr(c, r, 1, s), 4'($urandom_range(0, 15)));
      end
  endtask

  task automatic test_select_readback();
    logic [3:0] exp0;
    exp0 = m_main[0][2][5];
    cpu_src(1, 2, 5);
    cpu_cmd(4'h0, 4'hA);
    checks++; if (oe_cnt !== 0) begin $display("FAIL wrm_no_drive: got oe_cnt %0d expected 0", oe_cnt); errors++; end
    cpu_cmd(4'h9, 4'h0);
    checks++; if (oe_cnt !== 1 || oe_bad) begin $display("FAIL rdm_oe_window: got oe_cnt %0d bad %0d expected 1 0", oe_cnt, oe_bad); errors++; end
    checks++; if (rd_val !== 4'hA) begin $display("FAIL rdm_data: got %h expected a", rd_val); errors++; end
    host_op(1'b0, haddr(1, 2, 0, 5), 4'h0);
    checks++; if (h_rd !== 4'hA) begin $display("FAIL host_read_written: got %h expected a", h_rd); errors++; end
    host_op(1'b0, haddr(0, 2, 0, 5), 4'h0);
    checks++; if (h_rd !== exp0) begin $display("FAIL chip0_unchanged: got %h expected %h", h_rd, exp0); errors++; end
  endtask

  task automatic test_ports();
    cpu_src(2, 0, 0);
    cpu_cmd(4'h1, 4'h3);
    checks++; if (io_out !== 12'h300) begin $display("FAIL wmp_chip2: got %h expected 300", io_out); errors++; end
    host_op(1'b1, haddr(2, 0, 1, 1), 4'h7);
    checks++; if (io_out !== 12'h300) begin $display("FAIL host_no_io: got %h expected 300", io_out); errors++; end
  endtask

  task automatic test_status();
    logic [3:0] exp_rd0;
    exp_rd0 = m_stat[0][3][0];
    cpu_src(0, 3, 0);
    cpu_cmd(4'h6, 4'h9);
    cpu_cmd(4'hE, 4'h0);
    checks++; if (oe_cnt !== 1 || rd_val !== 4'h9) begin $display("FAIL rd2: got %h oe_cnt %0d expected 9 1", rd_val, oe_cnt); errors++; end
    cpu_cmd(4'hC, 4'h0);
    checks++; if (rd_val !== exp_rd0) begin $display("FAIL rd0: got %h expected %h", rd_val, exp_rd0); errors++; end
    host_op(1'b0, haddr(0, 3, 1, 2), 4'h0);
    checks++; if (h_rd !== 4'h9) begin $display("FAIL host_status2: got %h expected 9", h_rd); errors++; end
  endtask

  task automatic test_out_of_range();
    logic [4*NC-1:0] io_before;
    io_before = io_out;
    cpu_src(3, 1, 7);
    cpu_cmd(4'h9, 4'h0);
    checks++; if (oe_cnt !== 0 || oe_bad) begin $display("FAIL oor_rdm_drive: got oe_cnt %0d bad %0d expected 0 0", oe_cnt, oe_bad); errors++; end
    cpu_cmd(4'h0, 4'h7);
    cpu_cmd(4'h1, 4'h5);
    checks++; if (io_out !== io_before) begin $display("FAIL oor_wmp: got %h expected %h", io_out, io_before); errors++; end
    host_op(1'b1, haddr(3, 1, 0, 7), 4'h6);
    host_op(1'b0, haddr(3, 1, 0, 7), 4'h0);
    checks++; if (h_rd !== 4'h0) begin $display("FAIL oor_host_rdata: got %h expected 0", h_rd); errors++; end
    for (int c = 0; c < NC; c++) begin
      host_op(1'b0, haddr(c, 1, 0, 7), 4'h0);
      checks++; if (h_rd !== m_main[c][1][7]) begin $display("FAIL oor_mem_unchanged chip%0d: got %h expected %h", c, h_rd, m_main[c][1][7]); errors++; end
    end
  endtask

  task automatic test_contention();
    cpu_src(0, 0, 1);
    hif.host_we = 1'b1; hif.host_addr = haddr(0, 0, 0, 0); hif.host_wdata = 4'hF;
    raise_ph = 5;
    cpu_cmd(4'h0, 4'h2);
    checks++; if (pending || h_lat !== 3) begin $display("FAIL host_at_x1_latency: got %0d pending %0d expected 3 0", h_lat, pending); errors++; end
    if (pending) host_wait();
    m_host(1'b1, haddr(0, 0, 0, 0), 4'hF);
    hif.host_addr = haddr(0, 0, 0, 2); hif.host_wdata = 4'hE;
    raise_ph = 2;
    cpu_cmd(4'h0, 4'h6);
    checks++; if (pending || h_lat !== 1) begin $display("FAIL host_at_a3_latency: got %0d pending %0d expected 1 0", h_lat, pending); errors++; end
    if (pending) host_wait();
    m_host(1'b1, haddr(0, 0, 0, 2), 4'hE);
    host_op(1'b0, haddr(0, 0, 0, 0), 4'h0);
    checks++; if (h_rd !== 4'hF) begin $display("FAIL contention_char0: got %h expected f", h_rd); errors++; end
    host_op(1'b0, haddr(0, 0, 0, 2), 4'h0);
    checks++; if (h_rd !== 4'hE) begin $display("FAIL contention_char2: got %h expected e", h_rd); errors++; end
    cpu_cmd(4'h9, 4'h0);
    checks++; if (rd_val !== 4'h6) begin $display("FAIL contention_char1: got %h expected 6", rd_val); errors++; end
  endtask

  task automatic test_reset_mid();
    int oe_seen = 0;
    int io_seen = 0;
    int g = 0;
    cpu_src(1, 0, 0);
    cpu_cmd(4'h1, 4'h5);
    checks++; if (io_out !== m_io_vec()) begin $display("FAIL io_before_reset: got %h expected %h", io_out, m_io_vec()); errors++; end
    while (ph != 0 && g < 16) begin tick(); g++; end
    for (int p = 0; p < 5; p++) begin
      cm_ram = (p == 4);
      dbus_in = (p == 4) ? 4'h9 : 4'h0;
      tick();
    end
    cm_ram = 1'b0; dbus_in = 4'h0;
    rst = 1'b1;
    hif.host_we = 1'b0; hif.host_addr = haddr(0, 0, 0, 0);
    hif.host_req = 1'b1; pending = 1; h_lat = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dbus_oe !== 1'b0) oe_seen++;
      if (io_out !== '0) io_seen++;
    end
    checks++; if (oe_seen != 0) begin $display("FAIL reset_mid_drive: got %0d driven clocks expected 0", oe_seen); errors++; end
    checks++; if (io_seen != 0) begin $display("FAIL reset_mid_io: got %0d nonzero clocks expected 0", io_seen); errors++; end
    checks++; if (!pending) begin $display("FAIL reset_mid_ack: got ack expected none"); errors++; end
    hif.host_req = 1'b0; pending = 0;
    rst = 1'b0; ph = 0;
    m_chip = 0; m_reg = 0; m_char = 0;
    for (int n = 0; n < 4; n++) m_io[n] = 4'h0;
    cpu_cmd(4'h9, 4'h0);
    checks++; if (rd_val !== m_main[0][0][0] || oe_cnt !== 1) begin $display("FAIL post_reset_addr: got %h oe_cnt %0d expected %h 1", rd_val, oe_cnt, m_main[0][0][0]); errors++; end
  endtask

  task automatic test_random();
    for (int it = 0; it < 120; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 2) begin
        cpu_src($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      end else if (r < 7) begin
        logic [3:0] opa = 4'($urandom_range(0, 15));
        logic [3:0] d = 4'($urandom_range(0, 15));
        bit exp_oe = m_sel() && is_read(opa);
        logic [3:0] exp_d = m_read(opa);
        cpu_cmd(opa, d);
        checks++; if (oe_cnt != (exp_oe ? 1 : 0) || oe_bad) begin $display("FAIL rand_oe opa %h: got %0d bad %0d expected %0d 0", opa, oe_cnt, oe_bad, exp_oe); errors++; end
        if (exp_oe) begin
          checks++; if (rd_val !== exp_d) begin $display("FAIL rand_rd opa %h: got %h expected %h", opa, rd_val, exp_d); errors++; end
        end
        checks++; if (io_out !== m_io_vec()) begin $display("FAIL rand_io: got %h expected %h", io_out, m_io_vec()); errors++; end
      end else begin
        bit we = 1'($urandom_range(0, 1));
        logic [8:0] a = 9'($urandom_range(0, 511));
        logic [3:0] exp_h = h_exp(a);
        host_op(we, a, 4'($urandom_range(0, 15)));
        if (!we) begin
          checks++; if (h_rd !== exp_h) begin $display("FAIL rand_host_rd addr %h: got %h expected %h", a, h_rd, exp_h); errors++; end
        end
      end
    end
    checks++; if (spurious != 0) begin $display("FAIL spurious_ack: got %0d expected 0", spurious); errors++; end
  endtask

  initial begin
    test_reset();
    preload();
    test_select_readback();
    test_ports();
    test_status();
    test_out_of_range();
    test_contention();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
